// File: rtl/memory_streamer_pkg.sv
// Shared types and constants for memory_read_streamer and its output buffer.
package memory_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUFFER_DEPTH = 2;
  localparam int COUNT_WIDTH  = $clog2(BUFFER_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer carrying {last, data}; push is unconditional,
// the producer uses the exposed count to guarantee space.
module stream_skid_buffer
  import memory_streamer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   push_last,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [WIDTH-1:0]       out_data,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]       head_data_r, tail_data_r, head_data_s, tail_data_s;
  logic                   head_last_r, tail_last_r, head_last_s, tail_last_s;
  logic [COUNT_WIDTH-1:0] count_r, count_s;
  logic                   valid_r, pop_s;

  assign pop_s = valid_r && out_ready;

  // Next contents: the head register feeds the outputs, so it only moves on pop or on a push into empty.
  always_comb begin
    head_data_s = head_data_r;
    head_last_s = head_last_r;
    tail_data_s = tail_data_r;
    tail_last_s = tail_last_r;
    count_s     = count_r;
    case ({push, pop_s})
      2'b10: begin
        if (count_r == COUNT_WIDTH'(0)) begin
          head_data_s = push_data;
          head_last_s = push_last;
        end else begin
          tail_data_s = push_data;
          tail_last_s = push_last;
        end
        count_s = count_r + COUNT_WIDTH'(1);
      end
      2'b01: begin
        head_data_s = tail_data_r;
        head_last_s = tail_last_r;
        count_s     = count_r - COUNT_WIDTH'(1);
      end
      2'b11: begin
        if (count_r == COUNT_WIDTH'(1)) begin
          head_data_s = push_data;
          head_last_s = push_last;
        end else begin
          head_data_s = tail_data_r;
          head_last_s = tail_last_r;
          tail_data_s = push_data;
          tail_last_s = push_last;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
    if (flush) begin
      count_s = COUNT_WIDTH'(0);
    end else begin
      count_s = count_s;
    end
    // A stale last flag must not linger once the buffer empties.
    if (count_s == COUNT_WIDTH'(0)) begin
      head_last_s = 1'b0;
    end else begin
      head_last_s = head_last_s;
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data_r <= '0;
      head_last_r <= 1'b0;
      tail_data_r <= '0;
      tail_last_r <= 1'b0;
      count_r     <= COUNT_WIDTH'(0);
      valid_r     <= 1'b0;
    end else begin
      head_data_r <= head_data_s;
      head_last_r <= head_last_s;
      tail_data_r <= tail_data_s;
      tail_last_r <= tail_last_s;
      count_r     <= count_s;
      valid_r     <= (count_s != COUNT_WIDTH'(0));
    end
  end

  assign out_valid = valid_r;
  assign out_last  = head_last_r;
  assign out_data  = head_data_r;
  assign count     = count_r;

endmodule

// File: rtl/memory_read_streamer.sv
// Streams a contiguous run of words from a 1-cycle-latency memory read port.
// Optional abort input enabled by defining MEMORY_READ_STREAMER_ABORT_EN.
module memory_read_streamer
  import memory_streamer_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter int LENGTHWIDTH  = ADDRESSWIDTH + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
`ifdef MEMORY_READ_STREAMER_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] start_address,
  input  logic [LENGTHWIDTH-1:0]  length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESSWIDTH-1:0] mem_read_address,
  input  logic [DATAWIDTH-1:0]    mem_read_data,
  output logic [DATAWIDTH-1:0]    out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready
);

  state_t                  state_r, state_s;
  logic [ADDRESSWIDTH-1:0] address_r;
  logic [LENGTHWIDTH-1:0]  issue_remaining_r, beat_remaining_r;
  logic                    inflight_r, inflight_last_r, busy_r, done_r;
  logic                    abort_s, pop_s, load_s, zero_start_s, finish_s, issue_s, done_next_s;
  logic                    buf_valid_s;
  logic [COUNT_WIDTH-1:0]  buf_count_s;
  logic [2:0]              occupancy_s;

  function automatic logic [ADDRESSWIDTH-1:0] wrap_increment(input logic [ADDRESSWIDTH-1:0] a);
    if (a == ADDRESSWIDTH'(DATADEPTH - 1)) begin
      return '0;
    end else begin
      return a + ADDRESSWIDTH'(1);
    end
  endfunction

`ifdef MEMORY_READ_STREAMER_ABORT_EN
  assign abort_s = abort && (state_r != IDLE);
`else
  assign abort_s = 1'b0;
`endif

  assign occupancy_s = 3'(buf_count_s) + 3'(inflight_r);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_s = IDLE;
        end else if (issue_s && (issue_remaining_r == LENGTHWIDTH'(1))) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (abort_s || finish_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control decodes; a read issues only when it cannot overflow the 2-entry buffer.
  always_comb begin
    pop_s        = buf_valid_s && out_ready;
    load_s       = (state_r == IDLE) && start && (length != LENGTHWIDTH'(0));
    zero_start_s = (state_r == IDLE) && start && (length == LENGTHWIDTH'(0));
    finish_s     = (state_r == DRAIN) && pop_s && (beat_remaining_r == LENGTHWIDTH'(1));
    issue_s      = (state_r == RUN) && !abort_s && (occupancy_s < (3'd2 + 3'(pop_s)));
    done_next_s  = zero_start_s || finish_s || abort_s;
  end

  // Address, counters, read pipeline tracking and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_r         <= '0;
      issue_remaining_r <= '0;
      beat_remaining_r  <= '0;
      inflight_r        <= 1'b0;
      inflight_last_r   <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      busy_r          <= (state_s != IDLE);
      done_r          <= done_next_s;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (issue_remaining_r == LENGTHWIDTH'(1));
      if (abort_s) begin
        issue_remaining_r <= '0;
        beat_remaining_r  <= '0;
      end else if (load_s) begin
        address_r         <= start_address;
        issue_remaining_r <= length;
        beat_remaining_r  <= length;
      end else begin
        if (issue_s) begin
          address_r         <= wrap_increment(address_r);
          issue_remaining_r <= issue_remaining_r - LENGTHWIDTH'(1);
        end else begin
          issue_remaining_r <= issue_remaining_r;
        end
        if (pop_s) begin
          beat_remaining_r <= beat_remaining_r - LENGTHWIDTH'(1);
        end else begin
          beat_remaining_r <= beat_remaining_r;
        end
      end
    end
  end

  stream_skid_buffer #(
    .WIDTH(DATAWIDTH)
  ) u_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort_s),
    .push      (inflight_r),
    .push_last (inflight_last_r),
    .push_data (mem_read_data),
    .out_ready (out_ready),
    .out_valid (buf_valid_s),
    .out_last  (out_last),
    .out_data  (out_data),
    .count     (buf_count_s)
  );

  assign out_valid        = buf_valid_s;
  assign busy             = busy_r;
  assign done             = done_r;
  assign mem_read_address = address_r;

endmodule

// File: tb/tb_memory_read_streamer.sv
// Self-checking bench for memory_read_streamer against a queue-free word-list reference.
module tb_memory_read_streamer;

  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int LW    = 11;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_address;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_read_address;
  logic [7:0]    mem_read_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
`ifdef MEMORY_READ_STREAMER_ABORT_EN
  logic          abort;
`endif

  logic [7:0] mem [DEPTH];
  int checks;
  int errors;
  int pat [5] = '{1, 0, 0, 1, 0};

  memory_read_streamer #(
    .DATAWIDTH(8),
    .DATADEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
`ifdef MEMORY_READ_STREAMER_ABORT_EN
    .abort            (abort),
`endif
    .start            (start),
    .start_address    (start_address),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_ready        (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory read port with one cycle of latency.
  always @(posedge clk) mem_read_data <= mem[mem_read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; expected words are mem[(sa+i) mod DEPTH], i < len, last on i == len-1.
  task automatic run_transfer(input int sa, input int len, input int mode);
    int c, beat, done_c, issued, first_c;
    logic prev_stall, prev_last;
    logic [7:0] prev_data;
    @(negedge clk);
    check("idle_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    start_address = AW'(sa);
    length = LW'(len);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_address = AW'($urandom_range(0, DEPTH - 1));
    length = LW'($urandom_range(0, 1023));
    c = 1;
    beat = 0;
    done_c = (len == 0) ? 1 : 0;
    first_c = 0;
    prev_stall = 1'b0;
    prev_data = 8'd0;
    prev_last = 1'b0;
    if (len != 0) check("addr_after_start", 32'(mem_read_address), 32'(sa));
    while (!(done_c != 0 && c > done_c + 1) && c < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (pat[(c - 1) % 5] != 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && len != 0 && done_c == 0) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      check("busy", 32'(busy), 32'((len != 0) && (done_c == 0 || c < done_c)));
      check("done", 32'(done), 32'(c == done_c));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (beat == len) check("no_extra_valid", 32'(out_valid), 32'd0);
      if (len != 0 && done_c == 0) begin
        issued = (int'(mem_read_address) - sa + DEPTH) % DEPTH;
        check("outstanding_le_2", 32'((issued - beat) <= 2), 32'd1);
      end
      if (out_valid && beat < len && first_c == 0) begin
        first_c = c;
        check("first_latency", 32'(c), 32'd3);
      end
      if (out_valid && out_ready && beat < len) begin
        check("data", 32'(out_data), 32'(mem[(sa + beat) % DEPTH]));
        check("last", 32'(out_last), 32'(beat == len - 1));
        if (mode == 0) check("throughput", 32'(c), 32'(beat + 3));
        if (beat == len - 1) done_c = c + 1;
        beat++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("transfer_bounded", 32'(c < 400), 32'd1);
    check("beats_delivered", 32'(beat), 32'(len));
  endtask

  initial begin
    int hs;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    start_address = '0;
    length = '0;
    out_ready = 1'b0;
`ifdef MEMORY_READ_STREAMER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(mem_read_address), 32'd0);
    reset_n = 1'b1;

    run_transfer(10, 4, 0);
    run_transfer(998, 4, 0);
    run_transfer(20, 6, 1);
    run_transfer(0, 0, 0);
    run_transfer(995, 10, 2);
    for (int t = 0; t < 4; t++)
      run_transfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 12), 2);

    // Reset after two of eight beats.
    @(negedge clk);
    start = 1'b1; start_address = AW'(100); length = LW'(8); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 20 && hs < 2; k++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    check("reset_beats_seen", 32'(hs), 32'd2);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_addr", 32'(mem_read_address), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_done", 32'(done), 32'd0);
      check("postrst_valid", 32'(out_valid), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end
    run_transfer(500, 5, 2);

`ifdef MEMORY_READ_STREAMER_ABORT_EN
    // Abort after three of eight beats.
    @(negedge clk);
    start = 1'b1; start_address = AW'(300); length = LW'(8); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 20 && hs < 3; k++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    check("abort_beats_seen", 32'(hs), 32'd3);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postabort_done", 32'(done), 32'd0);
      check("postabort_valid", 32'(out_valid), 32'd0);
      check("postabort_busy", 32'(busy), 32'd0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_done", 32'(done), 32'd0);
    run_transfer(7, 3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
